tmds_phase_tuner: RTL

//  Sequences HDMI PLL bit-clock phase: sweeps pll_delay over all 2^DELAY_W settings and scores each on TMDS control-word sync.

---
 rtl/tmds_phase_tuner_pkg.sv | 31 +++
 rtl/tmds_window_finder.sv | 85 ++++++++
 rtl/tmds_phase_tuner.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tmds_phase_tuner_pkg.sv
// ============================================================================
//  Module   : tmds_phase_tuner_pkg
//  Purpose  : Shared state encoding, counter width and helpers for the
//             TMDS bit-clock phase tuner.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tmds_phase_tuner_pkg;

  localparam int c_cnt_w           = 16;
  localparam int c_delay_w_default = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_STEP    = 3'd3,
    ST_SCAN    = 3'd4,
    ST_TUNED   = 3'd5,
    ST_FAIL    = 3'd6
  } tuner_state_t;

  function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] v,
                                                 input logic               en);
    return (en && (v != {c_cnt_w{1'b1}})) ? v + 1'b1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_window_finder.sv
// ============================================================================
//  Module   : tmds_window_finder
//  Purpose  : Finds the longest circular run of passing phase settings by
//             walking the pass map twice (2N cycles), one bit per cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tmds_window_finder #(
  parameter int DELAY_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [(1<<DELAY_W)-1:0]   pass_map,
  output logic                      done,
  output logic [DELAY_W:0]          len,
  output logic [DELAY_W-1:0]        centre
);

  localparam logic [DELAY_W:0] c_full     = (DELAY_W+1)'(1 << DELAY_W);
  localparam logic [DELAY_W:0] c_idx_last = '1;

  logic                r_run;
  logic [DELAY_W:0]    r_idx;
  logic [DELAY_W:0]    r_cur_len;
  logic [DELAY_W:0]    r_best_len;
  logic [DELAY_W-1:0]  r_cur_start;
  logic [DELAY_W-1:0]  r_best_start;
  logic [DELAY_W-1:0]  w_pos;
  logic                w_bit;
  logic [DELAY_W-1:0]  w_cur_start;
  logic [DELAY_W:0]    w_cur_len;

  assign w_pos       = r_idx[DELAY_W-1:0];
  assign w_bit       = pass_map[w_pos];
  assign w_cur_start = (r_cur_len == '0) ? w_pos : r_cur_start;
  assign w_cur_len   = (r_cur_len == c_full) ? r_cur_len : r_cur_len + 1'b1;

  // Strictly-greater update keeps the earliest-found run on ties, and
  // the second lap lets runs that wrap past N-1 reach their full length.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run        <= 1'b0;
      r_idx        <= '0;
      r_cur_len    <= '0;
      r_best_len   <= '0;
      r_cur_start  <= '0;
      r_best_start <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r_run        <= 1'b1;
        r_idx        <= '0;
        r_cur_len    <= '0;
        r_best_len   <= '0;
        r_cur_start  <= '0;
        r_best_start <= '0;
      end else if (r_run) begin
        if (w_bit) begin
          r_cur_start <= w_cur_start;
          r_cur_len   <= w_cur_len;
          if (w_cur_len > r_best_len) begin
            r_best_len   <= w_cur_len;
            r_best_start <= w_cur_start;
          end
        end else begin
          r_cur_len <= '0;
        end
        if (r_idx == c_idx_last) begin
          r_run <= 1'b0;
          done  <= 1'b1;
        end
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign len    = r_best_len;
  assign centre = r_best_start + r_best_len[DELAY_W:1];

endmodule

`default_nettype wire

// File: rtl/tmds_phase_tuner.sv
// ============================================================================
//  Module   : tmds_phase_tuner
//  Purpose  : Sweeps the HDMI PLL phase delay, scores each setting on TMDS
//             control-word sync and parks on the centre of the widest window.
//             Define TMDS_TUNER_TRACK_EN for in-service tracking and retune_cnt.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tmds_phase_tuner
  import tmds_phase_tuner_pkg::*;
#(
  parameter int DELAY_W        = c_delay_w_default,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int MEASURE_CYCLES = 65536,
  parameter int MIN_HITS       = 16,
  parameter int MAX_ERRS       = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      locked,
  input  logic                      sync_hit,
  input  logic                      sync_good,
  output logic [DELAY_W-1:0]        pll_delay,
  output logic                      busy,
  output logic                      tuned,
  output logic                      fail,
  output logic [(1<<DELAY_W)-1:0]   pass_map,
  output logic [DELAY_W:0]          win_len
`ifdef TMDS_TUNER_TRACK_EN
  ,
  output logic [7:0]                retune_cnt
`endif
);

  localparam logic [31:0]        c_settle_last  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]        c_measure_last = 32'(MEASURE_CYCLES - 1);
  localparam logic [DELAY_W-1:0] c_last_delay   = '1;

  tuner_state_t          r_state;
  logic [31:0]           r_cyc;
  logic [c_cnt_w-1:0]    r_good;
  logic [c_cnt_w-1:0]    r_err;
  logic [c_cnt_w-1:0]    w_good_nxt;
  logic [c_cnt_w-1:0]    w_err_nxt;
  logic                  w_cur_pass;
  logic                  w_accept;
  logic                  w_resweep;
  logic                  w_scan_start;
  logic                  w_scan_done;
  logic [DELAY_W:0]      w_len;
  logic [DELAY_W-1:0]    w_centre;

  assign w_good_nxt   = sat_inc(r_good, sync_hit & sync_good);
  assign w_err_nxt    = sat_inc(r_err,  sync_hit & ~sync_good);
  assign w_cur_pass   = (32'(r_good) >= 32'(MIN_HITS)) && (32'(r_err) <= 32'(MAX_ERRS));
  assign w_accept     = start && ((r_state == ST_IDLE) || (r_state == ST_TUNED) ||
                                  (r_state == ST_FAIL));
  assign w_scan_start = (r_state == ST_STEP) && (pll_delay == c_last_delay);

`ifdef TMDS_TUNER_TRACK_EN
  logic w_nxt_pass;
  // The window verdict includes this cycle's word, so it is judged on w_*_nxt.
  assign w_nxt_pass = (32'(w_good_nxt) >= 32'(MIN_HITS)) &&
                      (32'(w_err_nxt) <= 32'(MAX_ERRS));
  assign w_resweep  = (r_state == ST_TUNED) &&
                      (!locked || ((r_cyc == c_measure_last) && !w_nxt_pass));
`else
  assign w_resweep  = 1'b0;
`endif

  tmds_window_finder #(
    .DELAY_W (DELAY_W)
  ) u_finder (
    .clk      (clk),
    .reset    (reset),
    .start    (w_scan_start),
    .pass_map (pass_map),
    .done     (w_scan_done),
    .len      (w_len),
    .centre   (w_centre)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cyc     <= '0;
      r_good    <= '0;
      r_err     <= '0;
      pll_delay <= '0;
      busy      <= 1'b0;
      tuned     <= 1'b0;
      fail      <= 1'b0;
      pass_map  <= '0;
      win_len   <= '0;
`ifdef TMDS_TUNER_TRACK_EN
      retune_cnt <= '0;
`endif
    end else if (w_accept || w_resweep) begin
      r_state   <= ST_SETTLE;
      r_cyc     <= '0;
      r_good    <= '0;
      r_err     <= '0;
      pll_delay <= '0;
      pass_map  <= '0;
      tuned     <= 1'b0;
      fail      <= 1'b0;
      busy      <= 1'b1;
`ifdef TMDS_TUNER_TRACK_EN
      if (!w_accept && (retune_cnt != 8'hFF)) retune_cnt <= retune_cnt + 8'd1;
`endif
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (!locked) begin
            r_cyc <= '0;
          end else if (r_cyc == c_settle_last) begin
            r_cyc   <= '0;
            r_state <= ST_MEASURE;
          end else begin
            r_cyc <= r_cyc + 32'd1;
          end
        end
        ST_MEASURE: begin
          // Losing lock restarts this setting rather than scoring it.
          if (!locked) begin
            r_cyc   <= '0;
            r_good  <= '0;
            r_err   <= '0;
            r_state <= ST_SETTLE;
          end else begin
            r_good <= w_good_nxt;
            r_err  <= w_err_nxt;
            if (r_cyc == c_measure_last) begin
              r_cyc   <= '0;
              r_state <= ST_STEP;
            end else begin
              r_cyc <= r_cyc + 32'd1;
            end
          end
        end
        ST_STEP: begin
          pass_map[pll_delay] <= w_cur_pass;
          r_good <= '0;
          r_err  <= '0;
          r_cyc  <= '0;
          if (pll_delay == c_last_delay) begin
            r_state <= ST_SCAN;
          end else begin
            pll_delay <= pll_delay + 1'b1;
            r_state   <= ST_SETTLE;
          end
        end
        ST_SCAN: begin
          if (w_scan_done) begin
            busy <= 1'b0;
            if (w_len != '0) begin
              pll_delay <= w_centre;
              win_len   <= w_len;
              tuned     <= 1'b1;
              r_state   <= ST_TUNED;
            end else begin
              pll_delay <= '0;
              win_len   <= '0;
              fail      <= 1'b1;
              r_state   <= ST_FAIL;
            end
          end
        end
        ST_TUNED: begin
`ifdef TMDS_TUNER_TRACK_EN
          if (r_cyc == c_measure_last) begin
            r_cyc  <= '0;
            r_good <= '0;
            r_err  <= '0;
          end else begin
            r_cyc  <= r_cyc + 32'd1;
            r_good <= w_good_nxt;
            r_err  <= w_err_nxt;
          end
`endif
        end
        ST_IDLE, ST_FAIL: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
